// File: rtl/logic_op_pipeline_pkg.sv
// rtl/logic_op_pipeline_pkg.sv - shared types, defaults and the bitwise operation helper
package logic_op_pipeline_pkg;

   localparam int DEFAULT_WIDTH     = 8;
   localparam int DEFAULT_IN_STAGES = 1;
   localparam int MAX_WIDTH         = 64;

   typedef enum logic [1:0] {
      OP_AND  = 2'b00,
      OP_OR   = 2'b01,
      OP_XOR  = 2'b10,
      OP_NAND = 2'b11
   } op_e;

   // Operates at MAX_WIDTH; callers zero-extend operands and truncate the result.
   function automatic logic [MAX_WIDTH-1:0] apply_op(
      input logic [MAX_WIDTH-1:0] a,
      input logic [MAX_WIDTH-1:0] b,
      input op_e                  op
   );
      case (op)
         OP_AND:  return a & b;
         OP_OR:   return a | b;
         OP_XOR:  return a ^ b;
         default: return ~(a & b);
      endcase
   endfunction

endpackage

// File: rtl/logic_op_pipeline_if.sv
// rtl/logic_op_pipeline_if.sv - operand/result stream bundle with master and slave views
interface logic_op_pipeline_if #(
   parameter int WIDTH = logic_op_pipeline_pkg::DEFAULT_WIDTH
);
   import logic_op_pipeline_pkg::*;

   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic [1:0]       op_in;
   logic             valid_in;
   logic             ready_out;
   logic [WIDTH-1:0] q_out;
   logic             valid_out;
   logic             ready_in;

   modport master (
      output a_in, b_in, op_in, valid_in, ready_in,
      input  ready_out, q_out, valid_out
   );

   modport slave (
      input  a_in, b_in, op_in, valid_in, ready_in,
      output ready_out, q_out, valid_out
   );

endinterface

// File: rtl/logic_op_pipeline_pipe_slice.sv
// rtl/logic_op_pipeline_pipe_slice.sv - one valid/ready register slice with bubble collapsing
module pipe_slice #(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          s_tvalid,
   output logic          s_tready,
   input  logic [DW-1:0] s_tdata,
   output logic          m_tvalid,
   input  logic          m_tready,
   output logic [DW-1:0] m_tdata
);

   logic load;

   // An empty slice always loads, so bubbles are squeezed out under backpressure.
   assign load     = !m_tvalid || m_tready;
   assign s_tready = load;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_tvalid <= 1'b0;
         m_tdata  <= '0;
      end else if (load) begin
         m_tvalid <= s_tvalid;
         if (s_tvalid) begin
            m_tdata <= s_tdata;
         end
      end
   end

endmodule

// File: rtl/logic_op_pipeline.sv
// rtl/logic_op_pipeline.sv - operand register chain followed by a registered bitwise op result
module logic_op_pipeline
   import logic_op_pipeline_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter int IN_STAGES = DEFAULT_IN_STAGES
) (
   input  logic               clk,
   input  logic               reset_n,
   logic_op_pipeline_if.slave bus
);

   localparam int OPW = 2*WIDTH + 2;

   logic             res_in_ready;
   logic             last_valid;
   logic [OPW-1:0]   last_data;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   op_e              op_sel;
   logic [WIDTH-1:0] res_d;

   genvar k;
   generate
      for (k = 0; k < IN_STAGES; k++) begin : g_stage
         logic           in_valid;
         logic           in_ready;
         logic [OPW-1:0] in_data;
         logic           out_valid;
         logic           out_ready;
         logic [OPW-1:0] out_data;

         if (k == 0) begin : g_head
            assign in_valid      = bus.valid_in;
            assign in_data       = {bus.a_in, bus.b_in, bus.op_in};
            assign bus.ready_out = in_ready;
         end else begin : g_link
            assign in_valid = g_stage[k-1].out_valid;
            assign in_data  = g_stage[k-1].out_data;
         end

         if (k == IN_STAGES-1) begin : g_tail
            assign out_ready = res_in_ready;
         end else begin : g_fwd
            assign out_ready = g_stage[k+1].in_ready;
         end

         pipe_slice #(.DW(OPW)) u_slice (
            .clk      (clk),
            .reset_n  (reset_n),
            .s_tvalid (in_valid),
            .s_tready (in_ready),
            .s_tdata  (in_data),
            .m_tvalid (out_valid),
            .m_tready (out_ready),
            .m_tdata  (out_data)
         );
      end
   endgenerate

   assign last_valid = g_stage[IN_STAGES-1].out_valid;
   assign last_data  = g_stage[IN_STAGES-1].out_data;

   // The op travels with its operands, so later op_in changes never touch this result.
   assign op_a   = last_data[OPW-1 -: WIDTH];
   assign op_b   = last_data[2 +: WIDTH];
   assign op_sel = op_e'(last_data[1:0]);
   assign res_d  = WIDTH'(apply_op(MAX_WIDTH'(op_a), MAX_WIDTH'(op_b), op_sel));

   pipe_slice #(.DW(WIDTH)) u_result (
      .clk      (clk),
      .reset_n  (reset_n),
      .s_tvalid (last_valid),
      .s_tready (res_in_ready),
      .s_tdata  (res_d),
      .m_tvalid (bus.valid_out),
      .m_tready (bus.ready_in),
      .m_tdata  (bus.q_out)
   );

endmodule

// File: tb/tb_logic_op_pipeline.sv
// tb/tb_logic_op_pipeline.sv - randomized and directed bench over three pipeline configurations
module tb_logic_op_pipeline;

   localparam int NDUT = 3;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [7:0] drv_a = '0;
   logic [7:0] drv_b = '0;
   logic [1:0] drv_op = '0;
   logic       drv_valid = 1'b0;
   logic       drv_ready = 1'b0;

   logic       vout [NDUT];
   logic       rdy  [NDUT];
   logic [7:0] qout [NDUT];
   int         acc_cnt  [NDUT];
   int         emit_cnt [NDUT];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   function automatic int width_of(input int g);
      return (g == 2) ? 1 : 8;
   endfunction

   function automatic int stages_of(input int g);
      return (g == 0) ? 1 : ((g == 1) ? 3 : 2);
   endfunction

   function automatic logic [7:0] ref_op(input logic [7:0] x, input logic [7:0] y,
                                         input logic [1:0] o, input int w);
      logic [7:0] r;
      case (o)
         2'd0:    r = x & y;
         2'd1:    r = x | y;
         2'd2:    r = x ^ y;
         default: r = ~(x & y);
      endcase
      return r & 8'((1 << w) - 1);
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      localparam int W = width_of(g);
      localparam int S = stages_of(g);

      logic_op_pipeline_if #(.WIDTH(W)) bus ();

      assign bus.a_in     = drv_a[W-1:0];
      assign bus.b_in     = drv_b[W-1:0];
      assign bus.op_in    = drv_op;
      assign bus.valid_in = drv_valid;
      assign bus.ready_in = drv_ready;

      logic_op_pipeline #(.WIDTH(W), .IN_STAGES(S)) u_dut (
         .clk     (clk),
         .reset_n (reset_n),
         .bus     (bus)
      );

      assign vout[g] = bus.valid_out;
      assign rdy[g]  = bus.ready_out;
      assign qout[g] = 8'(bus.q_out);

      logic [7:0] exp_q [$];
      int         acc    = 0;
      int         emit   = 0;
      bit         held   = 1'b0;
      logic [7:0] held_q = '0;

      assign acc_cnt[g]  = acc;
      assign emit_cnt[g] = emit;

      // Scoreboard: the queue holds results of accepted, not yet emitted transactions.
      always @(negedge clk) begin
         if (!reset_n) begin
            exp_q.delete();
            held = 1'b0;
         end else begin
            check_eq($sformatf("d%0d ready_out", g), 32'(rdy[g]),
                     32'(!(exp_q.size() == S + 1 && !drv_ready)));
            if (held) begin
               check_eq($sformatf("d%0d held valid", g), 32'(vout[g]), 32'(1));
               check_eq($sformatf("d%0d held q", g), 32'(qout[g]), 32'(held_q));
            end
            if (vout[g]) begin
               check_eq($sformatf("d%0d valid_out has txn", g), 32'(exp_q.size() != 0), 32'(1));
               if (drv_ready && exp_q.size() != 0) begin
                  check_eq($sformatf("d%0d q order", g), 32'(qout[g]), 32'(exp_q.pop_front()));
                  emit++;
               end
            end
            held   = vout[g] && !drv_ready;
            held_q = qout[g];
            if (drv_valid && rdy[g]) begin
               exp_q.push_back(ref_op(drv_a, drv_b, drv_op, W));
               acc++;
            end
         end
      end
   end

   task automatic run_pattern(input string name, input logic [7:0] pa, input logic [7:0] pb,
                              input bit pv [4], input logic [1:0] pops [4]);
      drv_ready = 1'b1;
      drv_a     = pa;
      drv_b     = pb;
      for (int n = 1; n <= 9; n++) begin
         drv_valid = (n <= 4) ? pv[n-1] : 1'b0;
         drv_op    = (n <= 4) ? pops[n-1] : 2'd0;
         tick();
         for (int g = 0; g < NDUT; g++) begin
            int idx;
            bit expv;
            idx  = n - stages_of(g) - 1;
            expv = (idx >= 0 && idx < 4) ? pv[idx] : 1'b0;
            check_eq($sformatf("%s d%0d valid_out n=%0d", name, g, n), 32'(vout[g]), 32'(expv));
            if (expv)
               check_eq($sformatf("%s d%0d q n=%0d", name, g, n), 32'(qout[g]),
                        32'(ref_op(pa, pb, pops[idx], width_of(g))));
         end
      end
   endtask

   initial begin
      bit         pv [4];
      logic [1:0] po [4];
      int         base [NDUT];

      reset_n = 1'b1;
      #1 reset_n = 1'b0;
      #1;
      for (int g = 0; g < NDUT; g++) begin
         check_eq($sformatf("reset d%0d valid_out", g), 32'(vout[g]), 32'(0));
         check_eq($sformatf("reset d%0d q_out", g), 32'(qout[g]), 32'(0));
         check_eq($sformatf("reset d%0d ready_out", g), 32'(rdy[g]), 32'(1));
      end
      tick();
      reset_n = 1'b1;
      tick();

      pv = '{1, 0, 0, 0}; po = '{2'd3, 2'd0, 2'd0, 2'd0};
      run_pattern("latency", 8'hF0, 8'hCC, pv, po);
      pv = '{1, 1, 1, 1}; po = '{2'd0, 2'd1, 2'd2, 2'd3};
      run_pattern("stream", 8'hF0, 8'hCC, pv, po);
      pv = '{1, 0, 0, 1}; po = '{2'd3, 2'd3, 2'd3, 2'd3};
      run_pattern("bubble", 8'hFF, 8'hFF, pv, po);

      // Backpressure: each pipe must fill to exactly its capacity, then drain in order.
      for (int g = 0; g < NDUT; g++) base[g] = acc_cnt[g];
      drv_ready = 1'b0;
      drv_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         drv_a  = 8'($urandom);
         drv_b  = 8'($urandom);
         drv_op = 2'($urandom);
         tick();
      end
      for (int g = 0; g < NDUT; g++) begin
         check_eq($sformatf("bp d%0d accepted", g), 32'(acc_cnt[g] - base[g]), 32'(stages_of(g) + 1));
         check_eq($sformatf("bp d%0d ready_out full", g), 32'(rdy[g]), 32'(0));
         base[g] = emit_cnt[g];
      end
      drv_valid = 1'b0;
      drv_ready = 1'b1;
      for (int i = 0; i < 8; i++) tick();
      for (int g = 0; g < NDUT; g++)
         check_eq($sformatf("bp d%0d drained", g), 32'(emit_cnt[g] - base[g]), 32'(stages_of(g) + 1));

      // Full pipe with both sides open: one accept and one emit every cycle.
      drv_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (i == 10)
            for (int g = 0; g < NDUT; g++) base[g] = emit_cnt[g];
         drv_a  = 8'($urandom);
         drv_b  = 8'($urandom);
         drv_op = 2'($urandom);
         tick();
      end
      for (int g = 0; g < NDUT; g++)
         check_eq($sformatf("full d%0d throughput", g), 32'(emit_cnt[g] - base[g]), 32'(10));

      for (int i = 0; i < 600; i++) begin
         drv_valid = ($urandom_range(0, 3) != 0);
         drv_ready = ($urandom_range(0, 9) < 7);
         drv_a     = 8'($urandom);
         drv_b     = 8'($urandom);
         drv_op    = 2'($urandom);
         tick();
      end
      drv_valid = 1'b0;
      drv_ready = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      for (int g = 0; g < NDUT; g++)
         check_eq($sformatf("random d%0d all emitted", g), 32'(emit_cnt[g]), 32'(acc_cnt[g]));

      // Mid-cycle reset with two transactions in flight; nothing may emerge afterwards.
      drv_ready = 1'b0;
      drv_valid = 1'b1;
      drv_a     = 8'h5A;
      drv_b     = 8'h0F;
      drv_op    = 2'd1;
      tick();
      tick();
      drv_valid = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      for (int g = 0; g < NDUT; g++) begin
         check_eq($sformatf("midreset d%0d valid_out", g), 32'(vout[g]), 32'(0));
         check_eq($sformatf("midreset d%0d q_out", g), 32'(qout[g]), 32'(0));
         check_eq($sformatf("midreset d%0d ready_out", g), 32'(rdy[g]), 32'(1));
      end
      tick();
      reset_n   = 1'b1;
      drv_ready = 1'b1;
      for (int g = 0; g < NDUT; g++) base[g] = emit_cnt[g];
      for (int i = 0; i < 10; i++) tick();
      for (int g = 0; g < NDUT; g++)
         check_eq($sformatf("postreset d%0d no output", g), 32'(emit_cnt[g] - base[g]), 32'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
